mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Memory controller that consumes the core controller's data-condition and length outputs.
- Buffers an input burst into internal RAM when condition = 100.
- Hands stored words one at a time to the processing register when condition = 010.
- Signals end of data with mc_data_done so the core controller returns to idle.

Parameters:
DATA_W, 8, width of one data word
ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64 words

Ports:
mc_clk  in  1  clock, rising edge
mc_reset  in  1  asynchronous, active-low reset
ctrl_data_contition  in  3  100 store, 010 transfer, 001 processing, 000 none
mc_data_length  in  6  burst length in words, sampled when a store starts
mc_data_in  in  DATA_W  input data word
mc_data_valid  in  1  mc_data_in valid this cycle
mc_data_ready  out  1  controller accepts mc_data_in this cycle
procc_done  in  1  processing unit finished current word
mc_reg_data  out  DATA_W  processing register, the word handed to the processing unit
mc_done  out  1  one-cycle pulse: store complete or word transferred
mc_data_done  out  1  all stored words delivered and the last one processed

Behaviour:
- Reset (mc_reset = 0, async): state = IDLE; wr_ptr, rd_ptr and len cleared; last_fetched cleared; mc_reg_data = 0; mc_done = 0. RAM contents are not reset.
- Registered outputs: mc_done, mc_reg_data. Combinational outputs: mc_data_ready = (state == STORE); mc_data_done = last_fetched & (cond == 001) & procc_done & (state == PROC).
- IDLE:
  - cond == 100: capture len = mc_data_length; wr_ptr = 0; rd_ptr = 0; last_fetched = 0.
  - If len != 0, go to STORE. If len == 0, pulse mc_done next cycle and go to STORED.
- STORE:
  - Each cycle with mc_data_valid = 1: write RAM[wr_ptr] = mc_data_in, then wr_ptr + 1.
  - The write that makes wr_ptr == len pulses mc_done in the following cycle; go to STORED.
  - mc_data_valid = 0 stalls indefinitely.
  - cond != 100: abort to IDLE, no mc_done.
- STORED: wait for cond == 010 (cond is still 100 during the mc_done cycle and is ignored), then go to FETCH_RD.
- FETCH_RD: RAM synchronous read of RAM[rd_ptr]; go to FETCH_LD.
- FETCH_LD:
  - Load mc_reg_data = read data; rd_ptr + 1; pulse mc_done; go to WAIT_ACK.
  - If the new rd_ptr == len, set last_fetched.
  - len == 0 case: skip the RAM read; mc_reg_data = 0; last_fetched = 1.
  - Latency: cond 010 seen to mc_done = 2 cycles.
- WAIT_ACK: wait for cond == 001 (cond is still 010 during the mc_done cycle; it must not re-fetch); go to PROC.
- PROC:
  - cond == 010: go to FETCH_RD (next word).
  - cond == 000: go to IDLE.
  - mc_data_done is high only in the cycle procc_done = 1 with last_fetched set.
- Any state other than STORE/IDLE seeing cond == 000: return to IDLE, pointers cleared. Illegal cond codes (011, 101, 110, 111) are treated as 000.
- Width rules: pointers are ADDR_W bits. A length of 63 never wraps. A length above 2**ADDR_W − 1 is impossible with 6-bit length and 64-word depth.
- mc_done is never high for two consecutive cycles.
- mc_data_valid outside STORE is ignored; no RAM write.
- Reset asserted mid-burst: immediate return to IDLE. Any partial data is discarded logically.

Test Plan:
- Reset: mc_reset low during STORE with wr_ptr = 5 -> outputs 0, state IDLE; next cond 100 with length 3 restarts at address 0.
- Store 4 words (11, 22, 33, 44) with valid gaps -> mc_data_ready high throughout; single mc_done pulse 1 cycle after 4th accepted word; RAM[0..3] correct.
- Full flow with core controller, length 3: three fetches give mc_reg_data 11, 22, 33, each 2 cycles after cond 010 -> third procc_done raises mc_data_done in that same cycle; cond returns 000; state IDLE.
- Length 0: cond 100 -> mc_done after 1 cycle; cond 010 -> mc_done with mc_reg_data = 0; first procc_done -> mc_data_done.
- Max length 63 with back-to-back valid -> mc_done exactly 63 cycles after first accept; 63 fetches return words in order, no pointer wrap.
- Abort: cond drops 100 -> 000 after 2 of 5 words -> no mc_done, mc_data_ready low next cycle, state IDLE.

Source files
------------

// File: rtl/mem_controller.sv
// Memory controller: buffers a burst into a local RAM on the store command,
// then hands the stored words one at a time to the processing register.
module mem_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic [2:0]        ctrl_data_contition,
  input  logic [5:0]        mc_data_length,
  input  logic [DATA_W-1:0] mc_data_in,
  input  logic              mc_data_valid,
  output logic              mc_data_ready,
  input  logic              procc_done,
  output logic [DATA_W-1:0] mc_reg_data,
  output logic              mc_done,
  output logic              mc_data_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_STORED,
    S_FETCH_RD,
    S_FETCH_LD,
    S_WAIT_ACK,
    S_PROC
  } state_t;

  // Illegal condition codes collapse to CMD_NONE.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_STORE,
    CMD_XFER,
    CMD_PROC
  } cmd_t;

  state_t              state, state_nxt;
  cmd_t                cmd;
  logic [ADDR_W-1:0]   len, len_nxt;
  logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic [ADDR_W-1:0]   wr_ptr_inc, rd_ptr_inc;
  logic                last_fetched, last_fetched_nxt;
  logic [DATA_W-1:0]   reg_data_nxt;
  logic                done_nxt;
  logic                ram_we, ram_re;
  logic                drop;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   rd_data;

  always_comb begin
    unique case (ctrl_data_contition)
      3'b100:  cmd = CMD_STORE;
      3'b010:  cmd = CMD_XFER;
      3'b001:  cmd = CMD_PROC;
      default: cmd = CMD_NONE;
    endcase
  end

  assign wr_ptr_inc = wr_ptr + ADDR_W'(1);
  assign rd_ptr_inc = rd_ptr + ADDR_W'(1);

  // STORE handles its own abort (any non-store code, no mc_done); IDLE has nothing to drop.
  assign drop = (state != S_IDLE) && (state != S_STORE) && (cmd == CMD_NONE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt        = state;
    len_nxt          = len;
    wr_ptr_nxt       = wr_ptr;
    rd_ptr_nxt       = rd_ptr;
    last_fetched_nxt = last_fetched;
    reg_data_nxt     = mc_reg_data;
    done_nxt         = 1'b0;
    ram_we           = 1'b0;
    ram_re           = 1'b0;

    if (drop) begin
      state_nxt        = S_IDLE;
      wr_ptr_nxt       = '0;
      rd_ptr_nxt       = '0;
      last_fetched_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd == CMD_STORE) begin
            len_nxt          = ADDR_W'(mc_data_length);
            wr_ptr_nxt       = '0;
            rd_ptr_nxt       = '0;
            last_fetched_nxt = 1'b0;
            if (mc_data_length != '0) begin
              state_nxt = S_STORE;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = S_STORED;
            end
          end
        end

        S_STORE: begin
          if (cmd != CMD_STORE) begin
            state_nxt  = S_IDLE;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
          end else if (mc_data_valid) begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr_inc;
            if (wr_ptr_inc == len) begin
              done_nxt  = 1'b1;
              state_nxt = S_STORED;
            end
          end
        end

        // The store command is still present while mc_done is high; only a transfer moves on.
        S_STORED: begin
          if (cmd == CMD_XFER) state_nxt = S_FETCH_RD;
        end

        S_FETCH_RD: begin
          ram_re    = (len != '0);
          state_nxt = S_FETCH_LD;
        end

        S_FETCH_LD: begin
          done_nxt   = 1'b1;
          rd_ptr_nxt = rd_ptr_inc;
          state_nxt  = S_WAIT_ACK;
          if (len == '0) begin
            reg_data_nxt     = '0;
            last_fetched_nxt = 1'b1;
          end else begin
            reg_data_nxt     = rd_data;
            last_fetched_nxt = last_fetched | (rd_ptr_inc == len);
          end
        end

        // Transfer is still asserted during the mc_done cycle and must not start another fetch.
        S_WAIT_ACK: begin
          if (cmd == CMD_PROC) state_nxt = S_PROC;
        end

        S_PROC: begin
          if (cmd == CMD_XFER) state_nxt = S_FETCH_RD;
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state        <= S_IDLE;
      len          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_fetched <= 1'b0;
      mc_reg_data  <= '0;
      mc_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= state_nxt;
      len          <= len_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      last_fetched <= last_fetched_nxt;
      mc_reg_data  <= reg_data_nxt;
      mc_done      <= done_nxt;
    end
  end

  // NOTE: the RAM array has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge mc_clk) begin
    if (ram_we) ram[wr_ptr] <= mc_data_in;
    if (ram_re) rd_data <= ram[rd_ptr];
  end

  assign mc_data_ready = (state == S_STORE);
  assign mc_data_done  = last_fetched && (cmd == CMD_PROC) && procc_done && (state == S_PROC);

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: a vector table for a full length-3 flow,
// plus scoreboard-driven store/fetch sequences for the multi-cycle corner cases.
module tb_mem_controller;

  localparam logic [2:0] C_NO = 3'b000;
  localparam logic [2:0] C_ST = 3'b100;
  localparam logic [2:0] C_XF = 3'b010;
  localparam logic [2:0] C_PR = 3'b001;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic       mc_clk = 1'b0;
  logic       mc_reset;
  logic [2:0] cond;
  logic [5:0] length;
  logic [7:0] din;
  logic       valid;
  logic       ready;
  logic       pd;
  logic [7:0] reg_data;
  logic       done;
  logic       data_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];
  logic [7:0] words [64];

  typedef struct {
    logic [2:0] cond;
    logic       valid;
    logic [7:0] din;
    logic       pd;
    logic       exp_ready;
    logic       exp_done;
    logic       exp_ddone;
    logic       chk_reg;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vt [26];

  mem_controller #(.DATA_W(8), .ADDR_W(6)) dut (
    .mc_clk              (mc_clk),
    .mc_reset            (mc_reset),
    .ctrl_data_contition (cond),
    .mc_data_length      (length),
    .mc_data_in          (din),
    .mc_data_valid       (valid),
    .mc_data_ready       (ready),
    .procc_done          (pd),
    .mc_reg_data         (reg_data),
    .mc_done             (done),
    .mc_data_done        (data_done)
  );

  always #5 mc_clk = ~mc_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are sampled on return.
  task automatic drive(input logic [2:0] c, input logic v, input logic [7:0] d, input logic p);
    @(negedge mc_clk);
    cond  = c;
    valid = v;
    din   = d;
    pd    = p;
    #2;
  endtask

  task automatic store_burst(input int n, input int gap, input string tag);
    length = 6'(n);
    drive(C_ST, L, 8'h00, L);
    check($sformatf("%s idle ready", tag), ready, 8'(0));
    if (n == 0) begin
      drive(C_ST, L, 8'h00, L);
      check($sformatf("%s len0 done", tag), done, 8'(1));
      sb.push_back(8'h00);
      drive(C_ST, L, 8'h00, L);
      check($sformatf("%s len0 done once", tag), done, 8'(0));
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (gap != 0 && (i % gap) == 1) begin
        drive(C_ST, L, 8'hEE, L);
        check($sformatf("%s gap ready %0d", tag, i), ready, 8'(1));
        check($sformatf("%s gap done %0d", tag, i), done, 8'(0));
      end
      drive(C_ST, H, words[i], L);
      check($sformatf("%s ready %0d", tag, i), ready, 8'(1));
      check($sformatf("%s early done %0d", tag, i), done, 8'(0));
      sb.push_back(words[i]);
    end
    drive(C_ST, L, 8'h00, L);
    check($sformatf("%s store done", tag), done, 8'(1));
    check($sformatf("%s ready after", tag), ready, 8'(0));
    drive(C_ST, L, 8'h00, L);
    check($sformatf("%s done once", tag), done, 8'(0));
  endtask

  task automatic fetch_word(input logic last, input string tag);
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      drive(C_XF, L, 8'h00, L);
      check($sformatf("%s latency %0d", tag, k), done, 8'(0));
    end
    drive(C_XF, L, 8'h00, L);
    check($sformatf("%s fetch done", tag), done, 8'(1));
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0h with no expected word queued", tag, reg_data);
    end else begin
      exp = sb.pop_front();
      check($sformatf("%s reg data", tag), reg_data, exp);
    end
    drive(C_PR, L, 8'h00, L);
    check($sformatf("%s no refetch", tag), done, 8'(0));
    drive(C_PR, L, 8'h00, H);
    check($sformatf("%s data done", tag), data_done, 8'(last));
  endtask

  task automatic finish_flow(input string tag);
    drive(C_NO, L, 8'h00, L);
    check($sformatf("%s data done low", tag), data_done, 8'(0));
    drive(C_NO, L, 8'h00, L);
    check($sformatf("%s idle ready", tag), ready, 8'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{C_ST, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[1]  = '{C_ST, H, 8'h11, L, H, L, L, L, 8'h00};
    vt[2]  = '{C_ST, L, 8'h5A, L, H, L, L, L, 8'h00};
    vt[3]  = '{C_ST, H, 8'h22, L, H, L, L, L, 8'h00};
    vt[4]  = '{C_ST, H, 8'h33, L, H, L, L, L, 8'h00};
    vt[5]  = '{C_ST, L, 8'h00, L, L, H, L, L, 8'h00};
    vt[6]  = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[7]  = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[8]  = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[9]  = '{C_XF, L, 8'h00, L, L, H, L, H, 8'h11};
    vt[10] = '{C_PR, L, 8'h00, L, L, L, L, H, 8'h11};
    vt[11] = '{C_PR, L, 8'h00, H, L, L, L, H, 8'h11};
    vt[12] = '{C_XF, L, 8'h00, L, L, L, L, H, 8'h11};
    vt[13] = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[14] = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[15] = '{C_XF, L, 8'h00, L, L, H, L, H, 8'h22};
    vt[16] = '{C_PR, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[17] = '{C_PR, L, 8'h00, H, L, L, L, H, 8'h22};
    vt[18] = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[19] = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[20] = '{C_XF, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[21] = '{C_XF, L, 8'h00, L, L, H, L, H, 8'h33};
    vt[22] = '{C_PR, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[23] = '{C_PR, L, 8'h00, H, L, L, H, H, 8'h33};
    vt[24] = '{C_NO, L, 8'h00, L, L, L, L, L, 8'h00};
    vt[25] = '{C_NO, L, 8'h00, L, L, L, L, L, 8'h00};

    cond = C_NO; valid = L; din = 8'h00; pd = L; length = 6'd0;
    mc_reset = 1'b0;
    repeat (2) @(negedge mc_clk);
    #2;
    check("reset ready", ready, 8'(0));
    check("reset done", done, 8'(0));
    check("reset reg", reg_data, 8'h00);
    check("reset data_done", data_done, 8'(0));
    @(negedge mc_clk);
    mc_reset = 1'b1;

    // Full length-3 flow from the vector table.
    length = 6'd3;
    for (int i = 0; i < 26; i++) begin
      drive(vt[i].cond, vt[i].valid, vt[i].din, vt[i].pd);
      check($sformatf("vec%0d ready", i), ready, 8'(vt[i].exp_ready));
      check($sformatf("vec%0d done", i), done, 8'(vt[i].exp_done));
      check($sformatf("vec%0d data_done", i), data_done, 8'(vt[i].exp_ddone));
      if (vt[i].chk_reg) check($sformatf("vec%0d reg", i), reg_data, vt[i].exp_reg);
    end

    // Four words with valid gaps, read back in order.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    store_burst(4, 2, "st4");
    for (int i = 0; i < 4; i++) fetch_word(i == 3, $sformatf("st4 f%0d", i));
    finish_flow("st4");

    // Zero-length burst.
    store_burst(0, 0, "len0");
    fetch_word(H, "len0 f");
    finish_flow("len0");

    // Maximum length, back-to-back, no pointer wrap.
    for (int i = 0; i < 63; i++) words[i] = 8'(i * 5 + 3);
    store_burst(63, 0, "len63");
    for (int i = 0; i < 63; i++) fetch_word(i == 62, $sformatf("len63 f%0d", i));
    finish_flow("len63");

    // Abort after 2 of 5 words.
    length = 6'd5;
    drive(C_ST, L, 8'h00, L);
    drive(C_ST, H, 8'hA1, L);
    drive(C_ST, H, 8'hA2, L);
    drive(C_NO, L, 8'h00, L);
    check("abort ready same cycle", ready, 8'(1));
    check("abort done", done, 8'(0));
    drive(C_NO, L, 8'h00, L);
    check("abort ready next", ready, 8'(0));
    for (int k = 0; k < 3; k++) begin
      drive(C_NO, L, 8'h00, L);
      check($sformatf("abort no done %0d", k), done, 8'(0));
    end

    // Illegal code in STORED behaves as none: IDLE then ignores a transfer.
    words[0] = 8'h5C; words[1] = 8'h6D;
    store_burst(2, 0, "ill");
    drive(3'b111, L, 8'h00, L);
    for (int k = 0; k < 4; k++) begin
      drive(C_XF, H, 8'h77, L);
      check($sformatf("ill idle done %0d", k), done, 8'(0));
      check($sformatf("ill idle ready %0d", k), ready, 8'(0));
    end
    sb.delete();
    drive(C_NO, L, 8'h00, L);

    // Asynchronous reset mid-burst, then restart from address 0.
    length = 6'd8;
    drive(C_ST, L, 8'h00, L);
    for (int i = 0; i < 5; i++) drive(C_ST, H, 8'(8'hC0 + i), L);
    mc_reset = 1'b0;
    #1;
    check("midrst ready", ready, 8'(0));
    check("midrst done", done, 8'(0));
    check("midrst reg", reg_data, 8'h00);
    check("midrst data_done", data_done, 8'(0));
    drive(C_NO, L, 8'h00, L);
    mc_reset = 1'b1;
    words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC;
    store_burst(3, 0, "rst");
    for (int i = 0; i < 3; i++) fetch_word(i == 2, $sformatf("rst f%0d", i));
    finish_flow("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
